// File: rtl/daddr_gen_if.sv
// Bus bundle between the core controller and the data-address generator.
// DADDR_MODULO_EN adds the baseCtl/limCtl load strobes for circular addressing.
interface daddr_gen_if #(
  parameter int AW   = 16,
  parameter int NREG = 4,
  parameter int LW   = 4
);
  localparam int SW = $clog2(NREG);

  logic [AW-1:0] aluOut;
  logic          dAregCtl;
  logic [SW-1:0] regSel;
  logic [1:0]    mode;
  logic [AW-1:0] stride;
  logic          burst_start;
  logic [LW-1:0] burst_len;
  logic          mem_ready;
  logic [AW-1:0] dAddr;
  logic          dAddr_valid;
  logic          busy;
`ifdef DADDR_MODULO_EN
  logic          baseCtl;
  logic          limCtl;

  modport master (
    output aluOut, dAregCtl, regSel, mode, stride, burst_start, burst_len,
           mem_ready, baseCtl, limCtl,
    input  dAddr, dAddr_valid, busy
  );

  modport slave (
    input  aluOut, dAregCtl, regSel, mode, stride, burst_start, burst_len,
           mem_ready, baseCtl, limCtl,
    output dAddr, dAddr_valid, busy
  );
`else
  modport master (
    output aluOut, dAregCtl, regSel, mode, stride, burst_start, burst_len,
           mem_ready,
    input  dAddr, dAddr_valid, busy
  );

  modport slave (
    input  aluOut, dAregCtl, regSel, mode, stride, burst_start, burst_len,
           mem_ready,
    output dAddr, dAddr_valid, busy
  );
`endif
endinterface

// File: rtl/daddr_gen.sv
// Data-address generator: NREG pointers loaded from the ALU, each able to drive a
// valid/ready address burst with post-update. DADDR_MODULO_EN enables mode 11 circular addressing.
module daddr_gen #(
  parameter int AW   = 16,
  parameter int NREG = 4,
  parameter int LW   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  daddr_gen_if.slave bus
);
  localparam int SW = $clog2(NREG);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;
  localparam logic [1:0] MODE_MOD  = 2'b11;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [AW-1:0] r_ptr [NREG];
  logic [AW-1:0] r_dAddr;
  logic [LW-1:0] r_cnt;
  logic [SW-1:0] r_sel;
  logic [1:0]    r_mode;
  logic [AW-1:0] r_stride;
  logic          w_load;
  logic          w_start;
  logic          w_accept;
  logic [AW-1:0] w_cur;
  logic [AW-1:0] w_next;
`ifdef DADDR_MODULO_EN
  logic [AW-1:0] r_base  [NREG];
  logic [AW-1:0] r_limit [NREG];
  logic [AW:0]   w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Load and burst requests are only honoured in IDLE; a beat is accepted whenever BURST sees mem_ready.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = bus.dAregCtl;
        if (bus.burst_start && (bus.burst_len != '0)) begin
          w_start     = 1'b1;
          w_stateNext = BURST;
        end
      end
      BURST: begin
        w_accept = bus.mem_ready;
        if (w_accept && (r_cnt == LW'(1))) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Post-update of the active pointer; wrap-around is silent modulo 2^AW.
  always_comb begin
    w_cur = r_ptr[r_sel];
`ifdef DADDR_MODULO_EN
    w_sum = {1'b0, w_cur} + {1'b0, r_stride};
`endif
    case (r_mode)
      MODE_HOLD: w_next = w_cur;
      MODE_INC:  w_next = w_cur + r_stride;
      MODE_DEC:  w_next = w_cur - r_stride;
`ifdef DADDR_MODULO_EN
      MODE_MOD: begin
        if (w_sum > {1'b0, r_limit[r_sel]})
          w_next = r_base[r_sel] + w_sum[AW-1:0] - r_limit[r_sel] - AW'(1);
        else
          w_next = w_sum[AW-1:0];
      end
`else
      MODE_MOD:  w_next = w_cur;
`endif
      default:   w_next = w_cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_ptr[i] <= '0;
`ifdef DADDR_MODULO_EN
        r_base[i]  <= '0;
        r_limit[i] <= '1;
`endif
      end
      r_dAddr  <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_mode   <= MODE_HOLD;
      r_stride <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Load is write-through so a burst started on the same edge begins at the new value.
          if (w_load) begin
            r_ptr[bus.regSel] <= bus.aluOut;
            r_dAddr           <= bus.aluOut;
          end else begin
            r_dAddr <= r_ptr[bus.regSel];
          end
          if (w_start) begin
            r_sel    <= bus.regSel;
            r_mode   <= bus.mode;
            r_stride <= bus.stride;
            r_cnt    <= bus.burst_len;
          end
`ifdef DADDR_MODULO_EN
          if (bus.baseCtl) r_base[bus.regSel]  <= bus.aluOut;
          if (bus.limCtl)  r_limit[bus.regSel] <= bus.aluOut;
`endif
        end
        BURST: begin
          if (w_accept) begin
            r_ptr[r_sel] <= w_next;
            r_dAddr      <= w_next;
            r_cnt        <= r_cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dAddr       = r_dAddr;
  assign bus.dAddr_valid = (r_state == BURST);
  assign bus.busy        = (r_state == BURST);

endmodule

// File: tb/tb_daddr_gen.sv
// Scoreboard bench for daddr_gen: stimulus pushes expected beats from a reference model,
// a negedge monitor compares every presented beat. Honours DADDR_MODULO_EN like the design.
module tb_daddr_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   sbQ[$];
  int   ptrM[4];
  int   baseM[4];
  int   limM[4];

  daddr_gen_if bus ();

  daddr_gen dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: next address from the arithmetic rules of each mode
  function automatic int stepAddr(input int m, input int p, input int s, input int sel);
    int sum;
    case (m)
      1: return (p + s) % 65536;
      2: return (p - s + 65536) % 65536;
      3: begin
`ifdef DADDR_MODULO_EN
        sum = p + s;
        if (sum > limM[sel]) return (baseM[sel] + sum - limM[sel] - 1) % 65536;
        return sum;
`else
        sum = p;
        return sum;
`endif
      end
      default: return p;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.dAddr_valid) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedBeat actual=%0h required=none", bus.dAddr);
      end else begin
        checkOutput("beat", 32'(bus.dAddr), 32'(sbQ[0]));
        if (bus.mem_ready) void'(sbQ.pop_front());
      end
    end
  end

  task automatic idleInputs();
    bus.dAregCtl    = 1'b0;
    bus.burst_start = 1'b0;
    bus.mem_ready   = 1'b0;
`ifdef DADDR_MODULO_EN
    bus.baseCtl = 1'b0;
    bus.limCtl  = 1'b0;
`endif
  endtask

  task automatic loadPtr(input int sel, input int val);
    bus.regSel   = 2'(sel);
    bus.aluOut   = 16'(val);
    bus.dAregCtl = 1'b1;
    @(posedge clk); #1;
    bus.dAregCtl = 1'b0;
    ptrM[sel] = val;
    checkOutput("loadWriteThrough", 32'(bus.dAddr), 32'(val));
  endtask

`ifdef DADDR_MODULO_EN
  task automatic loadBaseLim(input int sel, input int b, input int l);
    bus.regSel  = 2'(sel);
    bus.aluOut  = 16'(b);
    bus.baseCtl = 1'b1;
    @(posedge clk); #1;
    bus.baseCtl = 1'b0;
    bus.aluOut  = 16'(l);
    bus.limCtl  = 1'b1;
    @(posedge clk); #1;
    bus.limCtl = 1'b0;
    baseM[sel] = b;
    limM[sel]  = l;
  endtask
`endif

  task automatic checkPtr(input int sel);
    idleInputs();
    bus.regSel = 2'(sel);
    @(posedge clk); #1;
    checkOutput($sformatf("ptr%0d", sel), 32'(bus.dAddr), 32'(ptrM[sel]));
  endtask

  // readyMode: 0 random ready plus junk control inputs, 1 two-cycle stall after first beat, 2 always ready
  task automatic applyStimulus(input int sel, input int m, input int s, input int len,
                               input bit loadToo, input int loadVal, input int readyMode);
    int p;
    int cyc;
    bus.regSel      = 2'(sel);
    bus.mode        = 2'(m);
    bus.stride      = 16'(s);
    bus.burst_len   = 4'(len);
    bus.burst_start = 1'b1;
    bus.dAregCtl    = loadToo;
    bus.aluOut      = 16'(loadVal);
    bus.mem_ready   = 1'b0;
    if (loadToo) ptrM[sel] = loadVal;
    if (len != 0) begin
      p = ptrM[sel];
      for (int i = 0; i < len; i++) begin
        sbQ.push_back(p);
        p = stepAddr(m, p, s, sel);
      end
      ptrM[sel] = p;
    end
    @(posedge clk); #1;
    bus.burst_start = 1'b0;
    bus.dAregCtl    = 1'b0;
    if (len == 0) begin
      checkOutput("len0Busy", 32'(bus.busy), 32'd0);
      checkOutput("len0Addr", 32'(bus.dAddr), 32'(ptrM[sel]));
      return;
    end
    checkOutput("startBusy", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      case (readyMode)
        1: bus.mem_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        2: bus.mem_ready = 1'b1;
        default: begin
          bus.mem_ready   = 1'($urandom_range(0, 1));
          bus.dAregCtl    = 1'($urandom_range(0, 1));
          bus.burst_start = 1'($urandom_range(0, 1));
          bus.regSel      = 2'($urandom_range(0, 3));
          bus.aluOut      = 16'($urandom_range(0, 65535));
          bus.burst_len   = 4'($urandom_range(0, 15));
`ifdef DADDR_MODULO_EN
          bus.baseCtl = 1'($urandom_range(0, 1));
          bus.limCtl  = 1'($urandom_range(0, 1));
`endif
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    idleInputs();
    checkOutput("endBusy", 32'(bus.busy), 32'd0);
    checkOutput("endValid", 32'(bus.dAddr_valid), 32'd0);
    checkOutput("beatsDrained", 32'(sbQ.size()), 32'd0);
    sbQ.delete();
    checkPtr(sel);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      ptrM[i]  = 0;
      baseM[i] = 0;
      limM[i]  = 65535;
    end
  endtask

  initial begin
    resetModel();
    rst_n         = 1'b0;
    bus.aluOut    = '0;
    bus.regSel    = '0;
    bus.mode      = '0;
    bus.stride    = '0;
    bus.burst_len = '0;
    idleInputs();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstDAddr", 32'(bus.dAddr), 32'd0);
    checkOutput("rstValid", 32'(bus.dAddr_valid), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    loadPtr(2, 16'h1234);
    checkPtr(2);

    loadPtr(1, 16'h0100);
    applyStimulus(1, 1, 4, 3, 1'b0, 0, 1);

    loadPtr(0, 16'h0002);
    applyStimulus(0, 2, 4, 2, 1'b0, 0, 2);

    applyStimulus(3, 1, 1, 1, 1'b1, 16'h0800, 2);
    applyStimulus(3, 1, 1, 0, 1'b0, 0, 2);

`ifdef DADDR_MODULO_EN
    loadBaseLim(0, 16'h0010, 16'h001F);
`endif
    loadPtr(0, 16'h001C);
    applyStimulus(0, 3, 8, 2, 1'b0, 0, 2);

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) == 0) loadPtr($urandom_range(0, 3), $urandom_range(0, 65535));
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535),
                    $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 65535), 0);
    end

    // Abort a 5-beat burst after its second accepted beat
    loadPtr(3, 16'h4000);
    sbQ.push_back(16'h4000);
    sbQ.push_back(16'h4010);
    bus.regSel      = 2'd3;
    bus.mode        = 2'b01;
    bus.stride      = 16'h0010;
    bus.burst_len   = 4'd5;
    bus.burst_start = 1'b1;
    @(posedge clk); #1;
    bus.burst_start = 1'b0;
    bus.mem_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortValid", 32'(bus.dAddr_valid), 32'd0);
    checkOutput("abortBusy", 32'(bus.busy), 32'd0);
    checkOutput("abortDAddr", 32'(bus.dAddr), 32'd0);
    checkOutput("abortBeats", 32'(sbQ.size()), 32'd0);
    sbQ.delete();
    resetModel();
    rst_n         = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) checkPtr(i);
    checkOutput("abortNoRestart", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
